vehicle_lamp_driver: RTL and testbench

//  Consumer end of the vehicle control interface: takes _gearState/_turnState from the

---
 rtl/vehicle_lamp_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_vehicle_lamp_driver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_lamp_driver.sv
// Exterior lamp driver: welcome/run/farewell sequencing, turn blink generator, flash counter.
// Optional feature macro HAZARD_EN: turn code 2'b10 blinks both turn lamps in phase.
module vehicle_lamp_driver #(
    parameter int BLINK_HALF_PERIOD = 4,
    parameter int WELCOME_CYCLES    = 8,
    parameter int FAREWELL_CYCLES   = 6
) (
    input  logic       clock,
    input  logic       _reset_n,
    input  logic [1:0] _gearState,
    input  logic [1:0] _turnState,
    output logic       _leftLamp,
    output logic       _rightLamp,
    output logic       _reverseLamp,
    output logic       _parkLamp,
    output logic [1:0] _lampState,
    output logic [7:0] _blinkCount
);

    localparam int SEQ_MAX = (WELCOME_CYCLES > FAREWELL_CYCLES) ? WELCOME_CYCLES : FAREWELL_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX);
    localparam int PHASE_W = $clog2(BLINK_HALF_PERIOD);

    localparam logic [SEQ_W-1:0]   WELCOME_LAST  = SEQ_W'(WELCOME_CYCLES - 1);
    localparam logic [SEQ_W-1:0]   FAREWELL_LAST = SEQ_W'(FAREWELL_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST    = PHASE_W'(BLINK_HALF_PERIOD - 1);

    localparam logic [1:0] GEAR_LOCK    = 2'b00;
    localparam logic [1:0] GEAR_PARKING = 2'b01;
    localparam logic [1:0] GEAR_REVERSE = 2'b10;

    localparam logic [1:0] TURN_NONE   = 2'b00;
    localparam logic [1:0] TURN_LEFT   = 2'b01;
    localparam logic [1:0] TURN_HAZARD = 2'b10;
    localparam logic [1:0] TURN_RIGHT  = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF      = 2'b00,
        ST_WELCOME  = 2'b01,
        ST_RUN      = 2'b10,
        ST_FAREWELL = 2'b11
    } lamp_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    lamp_state_e        state_q, state_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               blink_q, blink_d;
    logic [1:0]         prev_turn_q, prev_turn_d;
    logic [7:0]         blink_count_q, blink_count_d;
    logic               left_lamp_q, left_lamp_d;
    logic               right_lamp_q, right_lamp_d;
    logic               reverse_lamp_q, reverse_lamp_d;
    logic               park_lamp_q, park_lamp_d;

    logic [1:0]         turn_eff_s;
    logic               turn_active_s;
    logic               turn_change_s;
    logic               left_sel_s;
    logic               right_sel_s;

    // Turn code mapping; without hazard support 2'b10 collapses to no-turn.
    always_comb begin
`ifdef HAZARD_EN
        turn_eff_s = _turnState;
`else
        if (_turnState == TURN_HAZARD) begin
            turn_eff_s = TURN_NONE;
        end else begin
            turn_eff_s = _turnState;
        end
`endif
        turn_active_s = (turn_eff_s != TURN_NONE);
        turn_change_s = (turn_eff_s != prev_turn_q);
        left_sel_s    = (turn_eff_s == TURN_LEFT)  || (turn_eff_s == TURN_HAZARD);
        right_sel_s   = (turn_eff_s == TURN_RIGHT) || (turn_eff_s == TURN_HAZARD);
    end

    // Sequencing FSM next-state and welcome/farewell timer.
    always_comb begin
        state_d = state_q;
        seq_d   = {SEQ_W{1'b0}};
        case (state_q)
            ST_OFF: begin
                if (_gearState != GEAR_LOCK) begin
                    state_d = ST_WELCOME;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_WELCOME: begin
                if (_gearState == GEAR_LOCK) begin
                    state_d = ST_OFF;
                end else if (seq_q == WELCOME_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    seq_d = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (_gearState == GEAR_LOCK) begin
                    state_d = ST_FAREWELL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAREWELL: begin
                if (_gearState != GEAR_LOCK) begin
                    state_d = ST_WELCOME;
                end else if (seq_q == FAREWELL_LAST) begin
                    state_d = ST_OFF;
                end else begin
                    seq_d = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Blink generator; RUN entry counts as a turn change so the blink restarts lit.
    always_comb begin
        phase_d       = {PHASE_W{1'b0}};
        blink_d       = 1'b0;
        blink_count_d = 8'd0;
        prev_turn_d   = turn_eff_s;
        if (state_d == ST_RUN) begin
            if ((state_q != ST_RUN) || turn_change_s) begin
                blink_d = turn_active_s;
            end else if (turn_active_s) begin
                if (phase_q == PHASE_LAST) begin
                    blink_d = ~blink_q;
                    if (blink_q) begin
                        blink_count_d = sat_inc8(blink_count_q);
                    end else begin
                        blink_count_d = blink_count_q;
                    end
                end else begin
                    phase_d       = phase_q + {{(PHASE_W-1){1'b0}}, 1'b1};
                    blink_d       = blink_q;
                    blink_count_d = blink_count_q;
                end
            end else begin
                blink_count_d = blink_count_q;
            end
        end else begin
            blink_count_d = 8'd0;
        end
    end

    // Lamp outputs follow the state being entered on this edge.
    always_comb begin
        left_lamp_d    = 1'b0;
        right_lamp_d   = 1'b0;
        reverse_lamp_d = 1'b0;
        park_lamp_d    = 1'b0;
        case (state_d)
            ST_OFF: begin
                park_lamp_d = 1'b0;
            end
            ST_WELCOME: begin
                left_lamp_d  = 1'b1;
                right_lamp_d = 1'b1;
            end
            ST_RUN: begin
                park_lamp_d    = (_gearState == GEAR_PARKING);
                reverse_lamp_d = (_gearState == GEAR_REVERSE);
                left_lamp_d    = blink_d && left_sel_s;
                right_lamp_d   = blink_d && right_sel_s;
            end
            ST_FAREWELL: begin
                park_lamp_d = 1'b1;
            end
            default: begin
                park_lamp_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered lamp outputs.
    always_ff @(posedge clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q        <= ST_OFF;
            seq_q          <= {SEQ_W{1'b0}};
            phase_q        <= {PHASE_W{1'b0}};
            blink_q        <= 1'b0;
            prev_turn_q    <= 2'b00;
            blink_count_q  <= 8'd0;
            left_lamp_q    <= 1'b0;
            right_lamp_q   <= 1'b0;
            reverse_lamp_q <= 1'b0;
            park_lamp_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            phase_q        <= phase_d;
            blink_q        <= blink_d;
            prev_turn_q    <= prev_turn_d;
            blink_count_q  <= blink_count_d;
            left_lamp_q    <= left_lamp_d;
            right_lamp_q   <= right_lamp_d;
            reverse_lamp_q <= reverse_lamp_d;
            park_lamp_q    <= park_lamp_d;
        end
    end

    assign _leftLamp    = left_lamp_q;
    assign _rightLamp   = right_lamp_q;
    assign _reverseLamp = reverse_lamp_q;
    assign _parkLamp    = park_lamp_q;
    assign _lampState   = state_q;
    assign _blinkCount  = blink_count_q;

endmodule

// File: tb/tb_vehicle_lamp_driver.sv
// Directed bench for vehicle_lamp_driver at default parameters.
// obs packs {_lampState, _leftLamp, _rightLamp, _reverseLamp, _parkLamp}.
module tb_vehicle_lamp_driver;

    logic       clock;
    logic       _reset_n;
    logic [1:0] _gearState;
    logic [1:0] _turnState;
    logic       _leftLamp;
    logic       _rightLamp;
    logic       _reverseLamp;
    logic       _parkLamp;
    logic [1:0] _lampState;
    logic [7:0] _blinkCount;
    logic [5:0] obs;

    int n_checks;
    int n_fail;

    vehicle_lamp_driver dut (
        .clock        (clock),
        ._reset_n     (_reset_n),
        ._gearState   (_gearState),
        ._turnState   (_turnState),
        ._leftLamp    (_leftLamp),
        ._rightLamp   (_rightLamp),
        ._reverseLamp (_reverseLamp),
        ._parkLamp    (_parkLamp),
        ._lampState   (_lampState),
        ._blinkCount  (_blinkCount)
    );

    assign obs = {_lampState, _leftLamp, _rightLamp, _reverseLamp, _parkLamp};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_run();
        _reset_n   = 1'b0;
        #1;
        _reset_n   = 1'b1;
        _gearState = 2'b01;
        _turnState = 2'b00;
        for (int i = 0; i < 9; i++) step();
    endtask

    task automatic test_reset();
        _reset_n   = 1'b0;
        _gearState = 2'b00;
        _turnState = 2'b00;
        #2;
        n_checks++;
        if (obs !== 6'b00_0000 || _blinkCount !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: obs=%b cnt=%0d expected obs=000000 cnt=0", obs, _blinkCount);
        end
        step();
        _reset_n = 1'b1;
        step();
        step();
        n_checks++;
        if (obs !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL off_locked: obs=%b expected 000000", obs);
        end
    endtask

    task automatic test_welcome();
        _gearState = 2'b01;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (obs !== 6'b01_1100) begin
                n_fail++;
                $display("FAIL welcome_%0d: obs=%b expected 011100", i, obs);
            end
        end
        step();
        n_checks++;
        if (obs !== 6'b10_0001 || _blinkCount !== 8'd0) begin
            n_fail++;
            $display("FAIL run_entry: obs=%b cnt=%0d expected obs=100001 cnt=0", obs, _blinkCount);
        end
    endtask

    task automatic test_left_blink();
        logic exp_l;
        _gearState = 2'b11;
        _turnState = 2'b01;
        for (int i = 0; i < 22; i++) begin
            step();
            exp_l = ((i / 4) % 2 == 0) ? 1'b1 : 1'b0;
            n_checks++;
            if (obs !== {2'b10, exp_l, 3'b000}) begin
                n_fail++;
                $display("FAIL left_blink_%0d: obs=%b expected %b", i, obs, {2'b10, exp_l, 3'b000});
            end
        end
        n_checks++;
        if (_blinkCount !== 8'd3) begin
            n_fail++;
            $display("FAIL flash_count: got %0d expected 3", _blinkCount);
        end
    endtask

    task automatic test_back_to_back();
        _turnState = 2'b11;
        step();
        n_checks++;
        if (obs !== 6'b10_0100 || _blinkCount !== 8'd0) begin
            n_fail++;
            $display("FAIL left_to_right: obs=%b cnt=%0d expected obs=100100 cnt=0", obs, _blinkCount);
        end
        _gearState = 2'b10;
        step();
        n_checks++;
        if (obs !== 6'b10_0110) begin
            n_fail++;
            $display("FAIL reverse_on: obs=%b expected 100110", obs);
        end
        _gearState = 2'b11;
        step();
        n_checks++;
        if (obs !== 6'b10_0100) begin
            n_fail++;
            $display("FAIL reverse_off: obs=%b expected 100100", obs);
        end
    endtask

    task automatic test_farewell();
        _gearState = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (obs !== 6'b11_0001 || _blinkCount !== 8'd0) begin
                n_fail++;
                $display("FAIL farewell_%0d: obs=%b cnt=%0d expected obs=110001 cnt=0", i, obs, _blinkCount);
            end
        end
        step();
        n_checks++;
        if (obs !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL farewell_end: obs=%b expected 000000", obs);
        end
        goto_run();
        _gearState = 2'b00;
        step();
        step();
        _gearState = 2'b01;
        step();
        n_checks++;
        if (obs !== 6'b01_1100) begin
            n_fail++;
            $display("FAIL farewell_restart: obs=%b expected 011100", obs);
        end
    endtask

    task automatic test_gear_wins();
        goto_run();
        _gearState = 2'b11;
        _turnState = 2'b01;
        step();
        step();
        _gearState = 2'b00;
        _turnState = 2'b11;
        step();
        n_checks++;
        if (obs !== 6'b11_0001 || _blinkCount !== 8'd0) begin
            n_fail++;
            $display("FAIL gear_wins: obs=%b cnt=%0d expected obs=110001 cnt=0", obs, _blinkCount);
        end
    endtask

    task automatic test_hazard();
        logic exp_b;
        logic [7:0] exp_cnt;
        goto_run();
        _gearState = 2'b11;
        _turnState = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef HAZARD_EN
            exp_b = (i < 4) ? 1'b1 : 1'b0;
`else
            exp_b = 1'b0;
`endif
            n_checks++;
            if (obs !== {2'b10, exp_b, exp_b, 2'b00}) begin
                n_fail++;
                $display("FAIL hazard_%0d: obs=%b expected %b", i, obs, {2'b10, exp_b, exp_b, 2'b00});
            end
        end
`ifdef HAZARD_EN
        exp_cnt = 8'd1;
`else
        exp_cnt = 8'd0;
`endif
        n_checks++;
        if (_blinkCount !== exp_cnt) begin
            n_fail++;
            $display("FAIL hazard_count: got %0d expected %0d", _blinkCount, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        goto_run();
        _gearState = 2'b11;
        _turnState = 2'b01;
        step();
        step();
        n_checks++;
        if (obs !== 6'b10_1000) begin
            n_fail++;
            $display("FAIL pre_reset_blink: obs=%b expected 101000", obs);
        end
        #2;
        _reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b00_0000 || _blinkCount !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: obs=%b cnt=%0d expected obs=000000 cnt=0", obs, _blinkCount);
        end
        step();
        n_checks++;
        if (obs !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL reset_held: obs=%b expected 000000", obs);
        end
        _reset_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        _reset_n   = 1'b0;
        _gearState = 2'b00;
        _turnState = 2'b00;
        test_reset();
        test_welcome();
        test_left_blink();
        test_back_to_back();
        test_farewell();
        test_gear_wins();
        test_hazard();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
